ant_navigator: RTL and testbench
================================

# ant_navigator

Parametrised wall-following controller for the ant-maze agent and successor to the fixed left-wall controller. It keeps a wall on a configurable side using the two antennae and the bump sensor. When it is lost it probes back toward the wall at a configurable cadence. When wedged it detects the condition with a stuck counter and runs an escape manoeuvre, and on the goal signal it halts permanently. It sits between the maze sensor model and the movement actuator, one instance per ant.

## Interface
Parameters:
- WALL_SIDE, 0: wall followed: 0 = left-hand wall, 1 = right-hand wall.
- PROBE_STEPS, 1: forward steps between probing turns toward the wall when no antenna touches; range 1..15.
- STUCK_LIMIT, 8: consecutive turn-away cycles in FOLLOW that trigger ESCAPE; range 2..255.
- ESCAPE_STEPS, 4: forward steps in ESCAPE before returning to SEEK; range 1..255.
- PH_WIDTH, 2: pheromone bus width (used only with ANT_PHEROMONE_EN).
- PH_LOOP, 3: detected pheromone level meaning "own trail revisited"; must be < 2^PH_WIDTH.

Ports:
- Clock and reset: clk and rst_n. clk is the clock. rst_n is the reset, asynchronous, active-high.
- ant_l, in, 1: left antenna contact.
- ant_r, in, 1: right antenna contact.
- hit, in, 1: body bumped into a wall this cycle.
- escape, in, 1: goal reached; forces DONE.
- move, out, 2: action: 2'b00 HALT, 2'b01 RIGHT, 2'b10 LEFT, 2'b11 FORWARD (registered).
- done, out, 1: high while in DONE (registered).
- ph_drop, out, PH_WIDTH: pheromone to deposit (ANT_PHEROMONE_EN only; registered).
- ph_detected, in, PH_WIDTH: pheromone level under the ant (ANT_PHEROMONE_EN only).

## Operation
- Side mapping: near = wall-side antenna (ant_l when WALL_SIDE=0), far = opposite antenna. AWAY = turn away from the wall (RIGHT when WALL_SIDE=0), TOWARD = the opposite turn.
- States: SEEK (reset state), FOLLOW, ESCAPE, DONE.
- escape=1 in any state: next state is DONE with move=HALT. DONE is left only by reset.
- SEEK: move=FORWARD while ant_l=ant_r=0. On any antenna contact: move=HALT, go to FOLLOW, clear stuck_cnt and probe_cnt.
- FOLLOW, first matching rule wins:
  - hit → AWAY, stuck_cnt+1.
  - near&far → AWAY, stuck_cnt+1.
  - near only → FORWARD, stuck_cnt=0, probe_cnt=0.
  - far only → AWAY, stuck_cnt+1.
  - neither antenna, probe_cnt==0 → TOWARD, probe_cnt=PROBE_STEPS, stuck_cnt=0.
  - neither antenna, probe_cnt>0 → FORWARD, probe_cnt-1, stuck_cnt=0.
- stuck_cnt saturates at STUCK_LIMIT. The cycle that would make it equal STUCK_LIMIT instead issues AWAY, enters ESCAPE, and loads esc_cnt=ESCAPE_STEPS.
- ESCAPE:
  - hit → AWAY and reload esc_cnt.
  - Otherwise → FORWARD with esc_cnt-1.
  - The cycle esc_cnt reaches 0 goes to SEEK.
  - Antennae are ignored in ESCAPE.
- Counter widths: stuck_cnt and esc_cnt are 8 bits; probe_cnt is 4 bits. No wrap is permitted; all counters saturate or reload.

## Timing
- All outputs are registered. Inputs sampled at edge N determine move/done/ph_drop visible after edge N, so latency is one cycle.
- Reset asserted, including mid-manoeuvre, immediately gives:
  - move=HALT, done=0, ph_drop=0;
  - state=SEEK;
  - all counters 0.
- First action after reset deasserts is FORWARD at the first clock edge with no contact.
- Simultaneous escape and hit: escape wins. Simultaneous STUCK_LIMIT and PH_LOOP trigger: a single entry into ESCAPE.

## Configuration
- ANT_PHEROMONE_EN defined:
  - ph_drop and ph_detected ports exist.
  - ph_drop=1 on cycles whose issued move is FORWARD and ph_detected==0; otherwise ph_drop=0.
  - In FOLLOW, ph_detected≥PH_LOOP forces ESCAPE exactly as a STUCK_LIMIT trigger does (AWAY, load esc_cnt). This takes priority over all FOLLOW rules but not over escape.
- ANT_PHEROMONE_EN undefined: both ports are absent, and there is no loop detection or pheromone logic.

## Test plan
- Reset then no contact for 5 cycles → move=FORWARD each cycle. Then ant_l=1 for 1 cycle → move=HALT, state FOLLOW.
- WALL_SIDE=0, FOLLOW, PROBE_STEPS=2, no contact for 6 cycles → LEFT, FWD, FWD, LEFT, FWD, FWD. The same with WALL_SIDE=1 gives RIGHT in place of LEFT.
- STUCK_LIMIT=4, FOLLOW, ant_l=ant_r=1 held → RIGHT×4 then ESCAPE. With ESCAPE_STEPS=4 and antennae held: FWD×4, then SEEK with move=HALT (contact).
- ESCAPE with hit on the 2nd forward step → RIGHT, then 4 more FWD before SEEK.
- escape=1 in the middle of ESCAPE → next cycle move=HALT, done=1. Held for 10 cycles regardless of inputs. Reset pulse → done=0, SEEK.
- ANT_PHEROMONE_EN, PH_LOOP=3, FOLLOW with ph_detected=3 → AWAY, ESCAPE entered. ph_detected=0 with a FORWARD move → ph_drop=1.

Source files
------------

// File: rtl/ant_navigator.sv
// ---------------------------------------------------------------------------
// ant_navigator
//
// Wall-following controller for one maze ant. It keeps a wall on the side
// chosen by WALL_SIDE using the two antennae and the bump sensor. When no
// antenna touches, it probes back toward the wall every PROBE_STEPS forward
// steps. A run of STUCK_LIMIT turn-away decisions in FOLLOW starts an escape
// manoeuvre of ESCAPE_STEPS forward steps. The goal signal halts the ant
// until the next reset.
//
// Optional feature macro: ANT_PHEROMONE_EN
//   When defined, the ph_drop/ph_detected ports exist. The ant deposits
//   pheromone on fresh ground. Revisiting its own trail in FOLLOW
//   (ph_detected >= PH_LOOP) starts an escape.
//
// Ports
//   clk          clock
//   rst_n        asynchronous reset, active-high (legacy name)
//   ant_l/ant_r  left/right antenna contact
//   hit          body bumped a wall this cycle
//   escape       goal reached, forces DONE
//   move         registered action: 00 HALT, 01 RIGHT, 10 LEFT, 11 FORWARD
//   done         registered, high while in DONE
//   ph_drop      registered pheromone deposit (ANT_PHEROMONE_EN only)
//   ph_detected  pheromone level under the ant (ANT_PHEROMONE_EN only)
// ---------------------------------------------------------------------------
module ant_navigator #(
    parameter int unsigned WALL_SIDE    = 0,
    parameter int unsigned PROBE_STEPS  = 1,
    parameter int unsigned STUCK_LIMIT  = 8,
    parameter int unsigned ESCAPE_STEPS = 4,
    parameter int unsigned PH_WIDTH     = 2,
    parameter int unsigned PH_LOOP      = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ant_l,
    input  logic                ant_r,
    input  logic                hit,
    input  logic                escape,
    output logic [1:0]          move,
    output logic                done
`ifdef ANT_PHEROMONE_EN
    ,
    output logic [PH_WIDTH-1:0] ph_drop,
    input  logic [PH_WIDTH-1:0] ph_detected
`endif
);

    // Elaboration-time parameter range checks.
    if (WALL_SIDE > 1)
        $error("ant_navigator: WALL_SIDE must be 0 or 1");
    if (PROBE_STEPS < 1 || PROBE_STEPS > 15)
        $error("ant_navigator: PROBE_STEPS must be 1..15");
    if (STUCK_LIMIT < 2 || STUCK_LIMIT > 255)
        $error("ant_navigator: STUCK_LIMIT must be 2..255");
    if (ESCAPE_STEPS < 1 || ESCAPE_STEPS > 255)
        $error("ant_navigator: ESCAPE_STEPS must be 1..255");
    if (PH_WIDTH < 1 || PH_LOOP >= (32'd1 << PH_WIDTH))
        $error("ant_navigator: PH_LOOP must fit in PH_WIDTH bits");

    typedef enum logic [1:0] {
        ST_SEEK   = 2'd0,
        ST_FOLLOW = 2'd1,
        ST_ESCAPE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [1:0] MV_HALT  = 2'b00;
    localparam logic [1:0] MV_RIGHT = 2'b01;
    localparam logic [1:0] MV_LEFT  = 2'b10;
    localparam logic [1:0] MV_FWD   = 2'b11;

    // Turning away from the wall is RIGHT for a left-hand wall, and the
    // reverse for a right-hand wall.
    localparam logic [1:0] MV_AWAY   = (WALL_SIDE == 0) ? MV_RIGHT : MV_LEFT;
    localparam logic [1:0] MV_TOWARD = (WALL_SIDE == 0) ? MV_LEFT  : MV_RIGHT;

    localparam logic [7:0] STUCK_LAST = 8'(STUCK_LIMIT - 1);
    localparam logic [7:0] ESC_LOAD   = 8'(ESCAPE_STEPS);
    localparam logic [3:0] PROBE_LOAD = 4'(PROBE_STEPS);

    state_t     state, state_next;
    logic [7:0] stuck_cnt, stuck_next;
    logic [7:0] esc_cnt, esc_next;
    logic [3:0] probe_cnt, probe_next;
    logic [1:0] act;        // action decided this cycle, registered into move
    logic [1:0] move_next;
    logic       done_next;

    logic near, far, loop_hit;
    assign near = (WALL_SIDE == 0) ? ant_l : ant_r;
    assign far  = (WALL_SIDE == 0) ? ant_r : ant_l;

`ifdef ANT_PHEROMONE_EN
    logic [PH_WIDTH-1:0] ph_drop_next;
    assign loop_hit = (ph_detected >= PH_WIDTH'(PH_LOOP));
`else
    assign loop_hit = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State register, counters and registered outputs
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) assignments so every
    // register samples the values from before the edge, whatever the
    // order of statements.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state     <= ST_SEEK;
            stuck_cnt <= '0;
            esc_cnt   <= '0;
            probe_cnt <= '0;
            move      <= MV_HALT;
            done      <= 1'b0;
`ifdef ANT_PHEROMONE_EN
            ph_drop   <= '0;
`endif
        end else begin
            state     <= state_next;
            stuck_cnt <= stuck_next;
            esc_cnt   <= esc_next;
            probe_cnt <= probe_next;
            move      <= move_next;
            done      <= done_next;
`ifdef ANT_PHEROMONE_EN
            ph_drop   <= ph_drop_next;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state and counter logic, plus the action chosen this cycle
    // ------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        stuck_next = stuck_cnt;
        esc_next   = esc_cnt;
        probe_next = probe_cnt;
        act        = MV_HALT;

        if (escape) begin
            state_next = ST_DONE;
        end else begin
            unique case (state)
                ST_SEEK: begin
                    if (ant_l || ant_r) begin
                        state_next = ST_FOLLOW;
                        stuck_next = '0;
                        probe_next = '0;
                    end else begin
                        act = MV_FWD;
                    end
                end

                ST_FOLLOW: begin
                    if (loop_hit || ((hit || far) && stuck_cnt >= STUCK_LAST)) begin
                        // The turn that would reach the stuck limit, or a
                        // revisited trail, starts the escape manoeuvre.
                        // Both triggers together give one single entry.
                        act        = MV_AWAY;
                        state_next = ST_ESCAPE;
                        esc_next   = ESC_LOAD;
                        stuck_next = '0;
                    end else if (hit || far) begin
                        // hit, both antennae or far-only: turn away.
                        act        = MV_AWAY;
                        stuck_next = stuck_cnt + 8'd1;
                    end else if (near) begin
                        act        = MV_FWD;
                        stuck_next = '0;
                        probe_next = '0;
                    end else if (probe_cnt == '0) begin
                        act        = MV_TOWARD;
                        probe_next = PROBE_LOAD;
                        stuck_next = '0;
                    end else begin
                        act        = MV_FWD;
                        probe_next = probe_cnt - 4'd1;
                        stuck_next = '0;
                    end
                end

                ST_ESCAPE: begin
                    if (hit) begin
                        act      = MV_AWAY;
                        esc_next = ESC_LOAD;
                    end else begin
                        act = MV_FWD;
                        // esc_cnt is at least 1 in ESCAPE; the <= guard
                        // keeps it from wrapping.
                        if (esc_cnt <= 8'd1) begin
                            esc_next   = '0;
                            state_next = ST_SEEK;
                        end else begin
                            esc_next = esc_cnt - 8'd1;
                        end
                    end
                end

                ST_DONE: begin
                    act = MV_HALT;
                end

                default: begin
                    state_next = ST_SEEK;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output logic: values registered at the next edge
    // ------------------------------------------------------------------
    always_comb begin
        move_next = act;
        done_next = (state_next == ST_DONE);
`ifdef ANT_PHEROMONE_EN
        // Deposit only when stepping forward onto unmarked ground.
        ph_drop_next = (act == MV_FWD && ph_detected == '0) ? PH_WIDTH'(1) : '0;
`endif
    end

endmodule

// File: tb/tb_ant_navigator.sv
// ---------------------------------------------------------------------------
// tb_ant_navigator
//
// Scoreboard bench for ant_navigator. The driver applies stimulus on the
// falling edge. It advances a behavioural model of the navigation rules
// and queues the response expected after the next rising edge. A separate
// monitor samples the DUT 1 ns after every rising edge and compares the
// sample against the head of the queue. Directed sequences are followed by
// randomized stimulus.
// ---------------------------------------------------------------------------
module tb_ant_navigator;

    localparam int WALL_SIDE    = 0;
    localparam int PROBE_STEPS  = 2;
    localparam int STUCK_LIMIT  = 4;
    localparam int ESCAPE_STEPS = 4;
    localparam int PH_WIDTH     = 2;
    localparam int PH_LOOP      = 3;

`ifdef ANT_PHEROMONE_EN
    localparam bit PH_EN = 1'b1;
`else
    localparam bit PH_EN = 1'b0;
`endif

    localparam int HALT = 0, RIGHT = 1, LEFT = 2, FWD = 3;
    localparam int AWAY   = (WALL_SIDE == 0) ? RIGHT : LEFT;
    localparam int TOWARD = (WALL_SIDE == 0) ? LEFT : RIGHT;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b1;
    logic       ant_l  = 1'b0;
    logic       ant_r  = 1'b0;
    logic       hit    = 1'b0;
    logic       escape = 1'b0;
    logic [1:0] move;
    logic       done;
`ifdef ANT_PHEROMONE_EN
    logic [PH_WIDTH-1:0] ph_drop;
    logic [PH_WIDTH-1:0] ph_detected = '0;
`endif

    always #5 clk = ~clk;

    ant_navigator #(
        .WALL_SIDE   (WALL_SIDE),
        .PROBE_STEPS (PROBE_STEPS),
        .STUCK_LIMIT (STUCK_LIMIT),
        .ESCAPE_STEPS(ESCAPE_STEPS),
        .PH_WIDTH    (PH_WIDTH),
        .PH_LOOP     (PH_LOOP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ant_l      (ant_l),
        .ant_r      (ant_r),
        .hit        (hit),
        .escape     (escape),
        .move       (move),
`ifdef ANT_PHEROMONE_EN
        .done       (done),
        .ph_drop    (ph_drop),
        .ph_detected(ph_detected)
`else
        .done       (done)
`endif
    );

    // ------------------------------------------------------------------
    // Scoreboard and counters
    // ------------------------------------------------------------------
    typedef struct {
        int move;
        int done;
        int drop;
        int cyc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    task automatic check(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, required, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural reference model (rule-level, plain integers and names)
    // ------------------------------------------------------------------
    string m_mode  = "SEEK";
    int    m_stuck = 0;
    int    m_probe = 0;
    int    m_esc   = 0;

    task automatic model_reset();
        m_mode  = "SEEK";
        m_stuck = 0;
        m_probe = 0;
        m_esc   = 0;
    endtask

    task automatic model_start_escape(output int mv);
        mv      = AWAY;
        m_mode  = "ESCAPE";
        m_esc   = ESCAPE_STEPS;
        m_stuck = 0;
    endtask

    task automatic model_step(input bit l, input bit r, input bit h, input bit esc,
                              input int phd, output exp_t e);
        bit near_c, far_c;
        int mv;
        near_c = (WALL_SIDE == 0) ? l : r;
        far_c  = (WALL_SIDE == 0) ? r : l;
        mv     = HALT;

        if (esc) begin
            m_mode = "DONE";
        end else if (m_mode == "SEEK") begin
            if (l || r) begin
                m_mode  = "FOLLOW";
                m_stuck = 0;
                m_probe = 0;
            end else begin
                mv = FWD;
            end
        end else if (m_mode == "FOLLOW") begin
            if (PH_EN && phd >= PH_LOOP) begin
                model_start_escape(mv);
            end else if (h || far_c) begin
                mv = AWAY;
                m_stuck = m_stuck + 1;
                if (m_stuck == STUCK_LIMIT) model_start_escape(mv);
            end else if (near_c) begin
                mv      = FWD;
                m_stuck = 0;
                m_probe = 0;
            end else if (m_probe == 0) begin
                mv      = TOWARD;
                m_probe = PROBE_STEPS;
                m_stuck = 0;
            end else begin
                mv      = FWD;
                m_probe = m_probe - 1;
                m_stuck = 0;
            end
        end else if (m_mode == "ESCAPE") begin
            if (h) begin
                mv    = AWAY;
                m_esc = ESCAPE_STEPS;
            end else begin
                mv    = FWD;
                m_esc = m_esc - 1;
                if (m_esc == 0) m_mode = "SEEK";
            end
        end

        e.move = mv;
        e.done = (m_mode == "DONE") ? 1 : 0;
        e.drop = (PH_EN && mv == FWD && phd == 0) ? 1 : 0;
        e.cyc  = cyc;
    endtask

    // ------------------------------------------------------------------
    // Driver: one call per clock cycle
    // ------------------------------------------------------------------
    task automatic step(input bit l, input bit r, input bit h, input bit esc,
                        input int phd, input bit rst);
        exp_t e;
        @(negedge clk);
        cyc++;
        ant_l  = l;
        ant_r  = r;
        hit    = h;
        escape = esc;
`ifdef ANT_PHEROMONE_EN
        ph_detected = PH_WIDTH'(phd);
`endif
        if (rst) begin
            rst_n = 1'b1;
            model_reset();
            e.move = HALT;
            e.done = 0;
            e.drop = 0;
            e.cyc  = cyc;
            // The reset is asynchronous, so it must act before any clock edge.
            #1;
            check("async_reset_move", int'(move), HALT);
            check("async_reset_done", int'(done), 0);
        end else begin
            rst_n = 1'b0;
            model_step(l, r, h, esc, phd, e);
        end
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n, input bit l, input bit r, input bit h);
        for (int i = 0; i < n; i++) step(l, r, h, 1'b0, 1, 1'b0);
    endtask

    // ------------------------------------------------------------------
    // Monitor: compares each post-edge sample against the queue head
    // ------------------------------------------------------------------
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check($sformatf("move[c%0d]", e.cyc), int'(move), e.move);
                check($sformatf("done[c%0d]", e.cyc), int'(done), e.done);
`ifdef ANT_PHEROMONE_EN
                check($sformatf("ph_drop[c%0d]", e.cyc), int'(ph_drop), e.drop);
`endif
            end
        end
    end

    // Watchdog: the bench must always end on its own.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        // Reset, then free running with no contact: FORWARD every cycle.
        step(0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 1, 1);
        idle(5, 0, 0, 0);
        // First contact: HALT and enter FOLLOW.
        step(1, 0, 0, 0, 1, 0);
        // Lost wall: TOWARD, FWD, FWD, TOWARD, FWD, FWD.
        idle(6, 0, 0, 0);
        // Both antennae held: AWAY x STUCK_LIMIT, then ESCAPE forward steps,
        // then back in SEEK with contact giving HALT.
        idle(STUCK_LIMIT + ESCAPE_STEPS + 1, 1, 1, 0);
        // Re-enter ESCAPE, then a hit on the second forward step.
        idle(STUCK_LIMIT, 1, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 1, 0, 1, 0);
        idle(ESCAPE_STEPS + 1, 0, 0, 0);
        // Re-enter ESCAPE and raise the goal (together with hit) mid-manoeuvre.
        step(1, 0, 0, 0, 1, 0);
        idle(STUCK_LIMIT, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 1, 1, 1, 0);
        // DONE holds whatever the inputs do.
        for (int i = 0; i < 10; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'b0, $urandom_range(0, 3), 1'b0);
        // Reset pulse clears DONE.
        step(0, 0, 0, 0, 1, 1);
        idle(2, 0, 0, 0);
`ifdef ANT_PHEROMONE_EN
        // Trail revisited in FOLLOW forces ESCAPE; fresh ground drops pheromone.
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, PH_LOOP, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 2, 0);
        idle(3, 0, 0, 0);
`endif
        // Randomized stimulus with occasional resets and goal events.
        for (int i = 0; i < 3000; i++) begin
            bit l, r, h, g, rs;
            l  = ($urandom_range(0, 2) == 0);
            r  = ($urandom_range(0, 2) == 0);
            h  = ($urandom_range(0, 3) == 0);
            g  = ($urandom_range(0, 149) == 0);
            rs = ($urandom_range(0, 79) == 0);
            step(l, r, h, g, $urandom_range(0, 3), rs);
        end

        // Drain the scoreboard.
        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
